// File: rtl/approx_err_monitor_pkg.sv
// rtl/approx_err_monitor_pkg.sv - shared types and constants for the approximate-multiplier error monitor
// Contents: FSM state encoding, drain length, default counter/sum widths,
// operand/product widths shared with the 8x8 multiplier family.
package approx_err_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One cycle per pipeline stage (S1, S2) between acceptance and accumulation.
  localparam int DRAIN_CYCLES = 2;

  localparam int CNT_W_DEF = 17;
  localparam int SUM_W_DEF = 33;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

endpackage

// File: rtl/approx_err_calc.sv
// rtl/approx_err_calc.sv - two-stage exact-vs-approximate product error pipeline
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   valid_i            accepted triple on this cycle
//   a_i, b_i, prod_i   operands and approximate product
//   valid_o            valid_i delayed by two cycles
//   ed_o               |exact - approx|
//   diff_o             approx - exact, two's complement, PROD_W+1 bits
//   mis_o              approx != exact
module approx_err_calc
  import approx_err_monitor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic              valid_o,
  output logic [PROD_W-1:0] ed_o,
  output logic [PROD_W:0]   diff_o,
  output logic              mis_o
);

  logic              s1_v_q;
  logic [PROD_W-1:0] exact_q;
  logic [PROD_W-1:0] approx_q;
  logic              s2_v_q;
  logic [PROD_W-1:0] ed_q;
  logic [PROD_W:0]   diff_q;
  logic              mis_q;

  logic [PROD_W-1:0] exact_d;
  logic [PROD_W-1:0] ed_d;
  logic [PROD_W:0]   diff_d;

  // Zero-extend before multiplying so the full 16-bit product is kept.
  assign exact_d = {{(PROD_W-OP_W){1'b0}}, a_i} * {{(PROD_W-OP_W){1'b0}}, b_i};
  assign ed_d    = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
  assign diff_d  = {1'b0, approx_q} - {1'b0, exact_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      exact_q  <= '0;
      approx_q <= '0;
      ed_q     <= '0;
      diff_q   <= '0;
      mis_q    <= 1'b0;
    end else begin
      s1_v_q   <= valid_i;
      exact_q  <= exact_d;
      approx_q <= prod_i;
      s2_v_q   <= s1_v_q;
      ed_q     <= ed_d;
      diff_q   <= diff_d;
      mis_q    <= (ed_d != '0);
    end
  end

  assign valid_o = s2_v_q;
  assign ed_o    = ed_q;
  assign diff_o  = diff_q;
  assign mis_o   = mis_q;

endmodule

// File: rtl/approx_err_monitor.sv
// rtl/approx_err_monitor.sv - run-based error statistics for an 8x8 approximate multiplier
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a run (honoured in IDLE or DONE)
//   in_valid/in_ready        operand/product handshake
//   in_a, in_b, in_prod      operands and approximate product
//   busy, done               RUN/DRAIN and DONE indicators
//   sample_cnt               samples accepted in this run
//   err_sum, bias_sum        sum |exact-approx|, signed sum (approx-exact)
//   err_max, mismatch_cnt    largest error distance, count of nonzero errors
module approx_err_monitor
  import approx_err_monitor_pkg::*;
#(
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int SUM_W     = SUM_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_a,
  input  logic [OP_W-1:0]    in_b,
  input  logic [PROD_W-1:0]  in_prod,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [SUM_W-1:0]   err_sum,
  output logic [SUM_W:0]     bias_sum,
  output logic [PROD_W-1:0]  err_max,
  output logic [CNT_W-1:0]   mismatch_cnt
);

  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [1:0]        drain_q, drain_d;
  logic [SUM_W-1:0]  err_sum_q, err_sum_d;
  logic [SUM_W:0]    bias_q, bias_d;
  logic [PROD_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

  logic              accept;
  logic              calc_v;
  logic [PROD_W-1:0] calc_ed;
  logic [PROD_W:0]   calc_diff;
  logic              calc_mis;

  // ready_q is only ever set in RUN; the state term keeps stray beats out regardless.
  assign accept = in_valid && ready_q && (state_q == ST_RUN);

  approx_err_calc u_calc (
    .clk     (clk),
    .rst     (rst),
    .valid_i (accept),
    .a_i     (in_a),
    .b_i     (in_b),
    .prod_i  (in_prod),
    .valid_o (calc_v),
    .ed_o    (calc_ed),
    .diff_o  (calc_diff),
    .mis_o   (calc_mis)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    drain_d   = drain_q;
    err_sum_d = err_sum_q;
    bias_d    = bias_q;
    max_d     = max_q;
    mis_cnt_d = mis_cnt_q;

    // Accumulate first so that a clear on start (below) takes priority.
    if (calc_v) begin
      err_sum_d = err_sum_q + {{(SUM_W-PROD_W){1'b0}}, calc_ed};
      bias_d    = bias_q + {{(SUM_W-PROD_W){calc_diff[PROD_W]}}, calc_diff};
      max_d     = (calc_ed > max_q) ? calc_ed : max_q;
      mis_cnt_d = mis_cnt_q + {{(CNT_W-1){1'b0}}, calc_mis};
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          ready_d   = 1'b1;
          err_sum_d = '0;
          bias_d    = '0;
          max_d     = '0;
          mis_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == N_LAST) begin
            state_d = ST_DRAIN;
            ready_d = 1'b0;
            drain_d = 2'd0;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      drain_q   <= 2'd0;
      err_sum_q <= '0;
      bias_q    <= '0;
      max_q     <= '0;
      mis_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      drain_q   <= drain_d;
      err_sum_q <= err_sum_d;
      bias_q    <= bias_d;
      max_q     <= max_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign in_ready     = ready_q;
  assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign sample_cnt   = cnt_q;
  assign err_sum      = err_sum_q;
  assign bias_sum     = bias_q;
  assign err_max      = max_q;
  assign mismatch_cnt = mis_cnt_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// tb/tb_approx_err_monitor.sv - directed self-checking bench for approx_err_monitor
module tb_approx_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [15:0] in_prod;

  logic        s_ready, s_busy, s_done;
  logic [16:0] s_cnt, s_mis;
  logic [32:0] s_err;
  logic [33:0] s_bias;
  logic [15:0] s_max;

  logic        b_ready, b_busy, b_done;
  logic [16:0] b_cnt, b_mis;
  logic [32:0] b_err;
  logic [33:0] b_bias;
  logic [15:0] b_max;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  approx_err_monitor #(.N_SAMPLES(4)) u_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_ready),
    .in_a(in_a), .in_b(in_b), .in_prod(in_prod), .busy(s_busy), .done(s_done),
    .sample_cnt(s_cnt), .err_sum(s_err), .bias_sum(s_bias), .err_max(s_max),
    .mismatch_cnt(s_mis)
  );

  approx_err_monitor #(.N_SAMPLES(65536)) u_big (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .in_a(in_a), .in_b(in_b), .in_prod(in_prod), .busy(b_busy), .done(b_done),
    .sample_cnt(b_cnt), .err_sum(b_err), .bias_sum(b_bias), .err_max(b_max),
    .mismatch_cnt(b_mis)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_prod  = p;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_small(input string tag, input longint cnt, input longint err,
                           input longint bias, input longint mx, input longint mis);
    chk({tag, ".cnt"},  64'(s_cnt), cnt);
    chk({tag, ".err"},  64'(s_err), err);
    chk({tag, ".bias"}, 64'($signed(s_bias)), bias);
    chk({tag, ".max"},  64'(s_max), mx);
    chk({tag, ".mis"},  64'(s_mis), mis);
  endtask

  initial begin
    longint g_err;
    longint g_mis;
    logic [15:0] ex;
    logic [15:0] ap;
    int wait_cnt;

    rst   = 1'b1;
    start = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst.ready", 64'(s_ready), 0);
    chk("rst.busy",  64'(s_busy), 0);
    chk("rst.done",  64'(s_done), 0);
    chk_small("rst", 0, 0, 0, 0, 0);

    // Errors: 225 vs 200 (ed 25, diff -25), 256 vs 260 (ed 4, diff +4), two exact.
    pulse_start();
    chk("a.ready", 64'(s_ready), 1);
    chk("a.busy",  64'(s_busy), 1);
    drive(1'b1, 8'd15, 8'd15, 16'd200); tick();
    drive(1'b1, 8'd16, 8'd16, 16'd260); tick();
    drive(1'b1, 8'd3,  8'd5,  16'd15);  tick();
    drive(1'b1, 8'd0,  8'd0,  16'd0);   tick();
    chk("a.ready_drop", 64'(s_ready), 0);
    chk("a.busy_drain", 64'(s_busy), 1);
    chk("a.cnt_last",   64'(s_cnt), 4);
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    tick();
    chk("a.done_k1", 64'(s_done), 0);
    tick();
    chk("a.done_k2", 64'(s_done), 1);
    chk("a.busy_k2", 64'(s_busy), 0);
    chk_small("a", 4, 29, -21, 25, 2);

    // start in DONE clears statistics on the same edge.
    pulse_start();
    chk("b.busy", 64'(s_busy), 1);
    chk("b.done", 64'(s_done), 0);
    chk_small("b.clear", 0, 0, 0, 0, 0);
    drive(1'b1, 8'd3,   8'd5,   16'd15);    tick();
    drive(1'b1, 8'd15,  8'd15,  16'd225);   tick();
    drive(1'b1, 8'd255, 8'd255, 16'd65025); tick();
    drive(1'b1, 8'd0,   8'd0,   16'd0);     tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    tick();
    tick();
    chk("b.done_k2", 64'(s_done), 1);
    chk_small("b", 4, 0, 0, 0, 0);

    // Gapped valid, start ignored in RUN and DRAIN, extra beats uncounted.
    pulse_start();
    drive(1'b1, 8'd2,   8'd2,   16'd5);  tick();
    drive(1'b0, 8'd255, 8'd255, 16'd0);  tick();
    drive(1'b1, 8'd3,   8'd3,   16'd9);  tick();
    drive(1'b0, 8'd255, 8'd255, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c.cnt_after_start_run", 64'(s_cnt), 2);
    chk("c.busy_after_start_run", 64'(s_busy), 1);
    drive(1'b1, 8'd4,   8'd4,   16'd10);  tick();
    drive(1'b0, 8'd255, 8'd255, 16'd0);   tick();
    drive(1'b1, 8'd10,  8'd10,  16'd100); tick();
    chk("c.ready_drop", 64'(s_ready), 0);
    drive(1'b1, 8'd255, 8'd255, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c.done_k1", 64'(s_done), 0);
    tick();
    chk("c.done_k2", 64'(s_done), 1);
    chk_small("c", 4, 7, -5, 6, 2);
    tick();
    chk_small("c.frozen", 4, 7, -5, 6, 2);
    drive(1'b0, 8'd0, 8'd0, 16'd0);

    // Reset mid-run discards in-flight samples.
    pulse_start();
    drive(1'b1, 8'd15, 8'd15, 16'd200); tick();
    drive(1'b1, 8'd16, 8'd16, 16'd260); tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("d.ready", 64'(s_ready), 0);
    chk("d.busy",  64'(s_busy), 0);
    chk("d.done",  64'(s_done), 0);
    chk_small("d.rst", 0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk_small("d.flushed", 0, 0, 0, 0, 0);
    pulse_start();
    drive(1'b1, 8'd255, 8'd255, 16'd65000); tick();
    drive(1'b1, 8'd255, 8'd255, 16'd65000); tick();
    drive(1'b1, 8'd255, 8'd255, 16'd65000); tick();
    drive(1'b1, 8'd255, 8'd0,   16'd1);     tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    tick();
    tick();
    chk("d.done_k2", 64'(s_done), 1);
    chk_small("d", 4, 76, -74, 25, 4);

    // Exhaustive sweep against a product with its two low bits truncated.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_start();
    g_err = 0;
    g_mis = 0;
    for (int i = 0; i < 65536; i++) begin
      ex = 16'(i / 256) * 16'(i % 256);
      ap = ex & 16'hFFFC;
      g_err += longint'(ex - ap);
      if (ex != ap) g_mis++;
      drive(1'b1, 8'(i / 256), 8'(i % 256), ap);
      tick();
    end
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    wait_cnt = 0;
    while (!b_done && wait_cnt < 8) begin
      tick();
      wait_cnt++;
    end
    chk("e.done",       64'(b_done), 1);
    chk("e.done_delay", 64'(wait_cnt), 2);
    chk("e.cnt",        64'(b_cnt), 65536);
    chk("e.err",        64'(b_err), g_err);
    chk("e.bias",       64'($signed(b_bias)), -g_err);
    chk("e.max",        64'(b_max), 3);
    chk("e.mis",        64'(b_mis), g_mis);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Sequential error-characterisation stage that sits directly downstream of the 8x8 approximate multiplier. It accepts operand pairs together with the approximate 16-bit product through a valid/ready handshake and recomputes the exact product internally. Over a run of N samples it accumulates error statistics: error-distance sum, signed bias sum, maximum error distance and mismatch count. Its purpose is on-FPGA measurement of MED/NMED/ER for any multiplier variant in the family.

## Interface
- N_SAMPLES, 65536 — samples per run (exhaustive 8x8 sweep); legal range 1..2^CNT_W-1
- CNT_W, 17 — width of sample and mismatch counters
- SUM_W, 33 — width of error-distance sum (16 + CNT_W)
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE
- in_valid  in  1  operand/product triple valid
- in_ready  out  1  monitor can accept a triple
- in_a  in  8  multiplicand presented to the multiplier
- in_b  in  8  multiplier operand presented to the multiplier
- in_prod  in  16  approximate product from the multiplier
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE; statistics stable
- sample_cnt  out  CNT_W  samples accepted in current run
- err_sum  out  SUM_W  sum of |exact − approx|
- bias_sum  out  SUM_W+1  signed sum of (approx − exact), two's complement
- err_max  out  16  largest |exact − approx| seen
- mismatch_cnt  out  CNT_W  samples with approx ≠ exact

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset sets state IDLE.
- Reset values: in_ready=0, busy=0, done=0, all counters, sums and err_max = 0, pipeline valids = 0.
- IDLE/DONE + start: clear all statistics and sample_cnt, then enter RUN. The clear takes effect on the same edge.
- RUN: in_ready=1 while sample_cnt < N_SAMPLES. A transfer occurs when in_valid && in_ready; sample_cnt increments on that edge.
- On the edge accepting sample N_SAMPLES: in_ready drops immediately, and the FSM enters DRAIN with a 2-bit drain counter.
- DRAIN: lasts until both pipeline stages are empty, i.e. exactly 2 cycles. The FSM then enters DONE.
- DONE: done=1 and outputs frozen until start or rst.
- start in RUN or DRAIN is ignored. in_valid outside RUN is ignored and not counted.
- Pipeline:
  - S1 registers exact = in_a*in_b (16-bit, unsigned) and approx = in_prod.
  - S2 registers ed = |exact − approx| (16-bit), diff = approx − exact (17-bit signed) and mis = (ed≠0).
  - Accumulate stage: err_sum += ed (zero-extended); bias_sum += diff (sign-extended); err_max = max(err_max, ed); mismatch_cnt += mis.
- Widths guarantee no overflow for N_SAMPLES ≤ 2^CNT_W−1. No saturation logic.
- rst mid-run: everything returns to reset values in one cycle, and the in-flight pipeline is discarded.

## Timing
- Throughput: 1 sample/cycle with in_valid held high.
- Latency: a sample accepted at edge k enters S1 at k, S2 at k+1, and is reflected in the statistics after edge k+2.
- done rises at edge k+2 after the last acceptance, on the same edge as the final accumulation. Statistics are valid in the first cycle done is high.
- in_ready is registered and depends on state and sample_cnt only, not on in_valid.
- Minimum run of N_SAMPLES=1 takes start → 1 accept cycle → done 2 edges later.

## Structure
- Shared package/header holds: the FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3); the DRAIN_CYCLES=2 constant; default widths for CNT_W/SUM_W; and the 8-bit operand / 16-bit product width constants shared with the multiplier family.
- One sub-module, approx_err_calc: the S1/S2 pipeline. It takes in_a, in_b, in_prod and an input valid, and produces ed, diff, mis and a valid delayed by 2 cycles. The top level holds the FSM, counters and accumulators.

## Test plan
- N=4; triples (3,5,15), (15,15,225), (255,255,65025), (0,0,0) with exact products → err_sum=0, bias_sum=0, err_max=0, mismatch_cnt=0, done 2 edges after 4th accept.
- N=2; (15,15,200), (16,16,260) → err_sum=29, bias_sum=−21, err_max=25, mismatch_cnt=2.
- N=3 with in_valid toggled 1,0,1,0,1 → sample_cnt=3, in_ready low after 3rd accept, extra valid beats uncounted.
- Mid-run rst after 2 of N=8 accepts → next cycle all outputs 0, state IDLE, in_ready=0; new start runs cleanly.
- start pulsed during RUN and DRAIN → ignored; start in DONE → stats cleared, new run.
- Exhaustive N=65536 driven by an exact multiplier → done with err_sum=0 and sample_cnt=65536; repeat against the approximate multiplier and compare with the golden-model sums.
